// File: rtl/control_sequencer_pkg.sv
// Shared LC-3b types for the decode/micro-sequencing stage: opcodes, ALU ops,
// mux encodings, micro-op phase and the control word carried to ID/EX.
package control_sequencer_pkg;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [3:0] {
    OP_BR   = 4'h0, OP_ADD = 4'h1, OP_LDB = 4'h2, OP_STB  = 4'h3,
    OP_JSR  = 4'h4, OP_AND = 4'h5, OP_LDR = 4'h6, OP_STR  = 4'h7,
    OP_RTI  = 4'h8, OP_NOT = 4'h9, OP_LDI = 4'ha, OP_STI  = 4'hb,
    OP_JMP  = 4'hc, OP_SHF = 4'hd, OP_LEA = 4'he, OP_TRAP = 4'hf
  } lc3b_opcode;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0, ALU_AND = 3'd1, ALU_NOT = 3'd2, ALU_PASS = 3'd3,
    ALU_SLL  = 3'd4, ALU_SRL = 3'd5, ALU_SRA = 3'd6
  } lc3b_aluop;

  typedef enum logic {PHASE_0 = 1'b0, PHASE_1 = 1'b1} lc3b_uop_phase;

  // Memory address source
  localparam logic [1:0] ADDR_ALU     = 2'b00;
  localparam logic [1:0] ADDR_TRAPVEC = 2'b01;
  localparam logic [1:0] ADDR_MDR     = 2'b10;

  // ALU B-operand source
  localparam logic [1:0] ALUMUX_SR2       = 2'b00;
  localparam logic [1:0] ALUMUX_OFF6      = 2'b01;
  localparam logic [1:0] ALUMUX_IMM5      = 2'b10;
  localparam logic [1:0] ALUMUX_OFF6_BYTE = 2'b11;

  // Register-file write-back source
  localparam logic [2:0] RFMUX_ALU      = 3'b000;
  localparam logic [2:0] RFMUX_MDR      = 3'b001;
  localparam logic [2:0] RFMUX_PC       = 3'b010;
  localparam logic [2:0] RFMUX_MDR_BYTE = 3'b011;
  localparam logic [2:0] RFMUX_LEA      = 3'b100;

  typedef struct packed {
    lc3b_opcode opcode;
    lc3b_aluop  aluop;
    logic       load_cc;
    logic       load_regfile;
    logic [2:0] regfilemux_sel;
    logic [1:0] alumux_sel;
    logic [1:0] addr_sel;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_byte_enable;
    logic       is_br;
    logic       is_j;
    logic       is_jsr;
    logic       is_ldi;
    logic       is_sti;
    logic       is_trap;
    logic       use_byte;
  } lc3b_control_word;

endpackage

// File: rtl/control_sequencer_uop_decode.sv
// Combinational micro-op decode: one instruction plus phase -> control word,
// whether the instruction needs a second micro-op, and the illegal flag.
import control_sequencer_pkg::*;

module control_sequencer_uop_decode #(
  parameter bit INDIRECT_EN = 1'b1,
  parameter bit TRAP_SEQ_EN = 1'b1,
  parameter bit BYTE_EN     = 1'b1
) (
  input  lc3b_word         instr,
  input  lc3b_uop_phase    phase,
  output lc3b_control_word ctrl,
  output logic             multi,
  output logic             illegal
);

  lc3b_opcode opcode;
  assign opcode = lc3b_opcode'(instr[15:12]);

  // Per-opcode field decode; illegal opcodes collapse to an opcode-only word
  always_comb begin
    ctrl                 = '0;
    ctrl.opcode          = opcode;
    ctrl.mem_byte_enable = 2'b11;
    multi                = 1'b0;
    illegal              = 1'b0;
    case (opcode)
      OP_ADD, OP_AND: begin
        ctrl.aluop        = (opcode == OP_ADD) ? ALU_ADD : ALU_AND;
        ctrl.alumux_sel   = instr[5] ? ALUMUX_IMM5 : ALUMUX_SR2;
        ctrl.load_regfile = 1'b1;
        ctrl.load_cc      = 1'b1;
      end
      OP_NOT: begin
        ctrl.aluop        = ALU_NOT;
        ctrl.load_regfile = 1'b1;
        ctrl.load_cc      = 1'b1;
      end
      OP_SHF: begin
        ctrl.aluop        = !instr[4] ? ALU_SLL : (instr[5] ? ALU_SRA : ALU_SRL);
        ctrl.load_regfile = 1'b1;
        ctrl.load_cc      = 1'b1;
      end
      OP_BR: ctrl.is_br = 1'b1;
      OP_JMP: begin
        ctrl.is_j  = 1'b1;
        ctrl.aluop = ALU_PASS;
      end
      OP_JSR: begin
        ctrl.is_jsr         = 1'b1;
        ctrl.is_j           = !instr[11];
        ctrl.aluop          = ALU_PASS;
        ctrl.load_regfile   = 1'b1;
        ctrl.regfilemux_sel = RFMUX_PC;
      end
      OP_LEA: begin
        ctrl.load_regfile   = 1'b1;
        ctrl.regfilemux_sel = RFMUX_LEA;
        ctrl.load_cc        = 1'b1;
      end
      OP_LDR: begin
        ctrl.mem_read       = 1'b1;
        ctrl.alumux_sel     = ALUMUX_OFF6;
        ctrl.load_regfile   = 1'b1;
        ctrl.regfilemux_sel = RFMUX_MDR;
        ctrl.load_cc        = 1'b1;
      end
      OP_STR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.alumux_sel = ALUMUX_OFF6;
      end
      OP_LDB, OP_STB: begin
        if (!BYTE_EN) begin
          illegal = 1'b1;
        end else begin
          ctrl.use_byte   = 1'b1;
          ctrl.alumux_sel = ALUMUX_OFF6_BYTE;
          if (opcode == OP_LDB) begin
            ctrl.mem_read       = 1'b1;
            ctrl.load_regfile   = 1'b1;
            ctrl.regfilemux_sel = RFMUX_MDR_BYTE;
            ctrl.load_cc        = 1'b1;
          end else begin
            ctrl.mem_write = 1'b1;
          end
        end
      end
      OP_LDI, OP_STI: begin
        if (!INDIRECT_EN) begin
          illegal = 1'b1;
        end else begin
          multi       = 1'b1;
          ctrl.is_ldi = (opcode == OP_LDI);
          ctrl.is_sti = (opcode == OP_STI);
          if (phase == PHASE_0) begin
            // First access fetches the pointer from R + offset
            ctrl.mem_read   = 1'b1;
            ctrl.alumux_sel = ALUMUX_OFF6;
            ctrl.aluop      = ALU_ADD;
          end else begin
            ctrl.addr_sel = ADDR_MDR;
            if (opcode == OP_LDI) begin
              ctrl.mem_read       = 1'b1;
              ctrl.load_regfile   = 1'b1;
              ctrl.regfilemux_sel = RFMUX_MDR;
              ctrl.load_cc        = 1'b1;
            end else begin
              ctrl.mem_write = 1'b1;
            end
          end
        end
      end
      OP_TRAP: begin
        multi        = TRAP_SEQ_EN;
        ctrl.is_trap = 1'b1;
        if (phase == PHASE_0) begin
          ctrl.mem_read       = 1'b1;
          ctrl.addr_sel       = ADDR_TRAPVEC;
          ctrl.load_regfile   = 1'b1;
          ctrl.regfilemux_sel = RFMUX_PC;
        end else begin
          ctrl.is_j  = 1'b1;
          ctrl.aluop = ALU_PASS;
        end
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      ctrl        = '0;
      ctrl.opcode = opcode;
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Decode/micro-sequencing stage between IF/ID and ID/EX. Emits one micro-op
// per instruction, or two for LDI/STI/TRAP, behind a valid/ready output register.
//
//   state   | meaning
//   S_ISSUE | accepting new instructions
//   S_SEQ   | second micro-op pending, instruction held in instr_q
import control_sequencer_pkg::*;

module control_sequencer #(
  parameter bit INDIRECT_EN = 1'b1,
  parameter bit TRAP_SEQ_EN = 1'b1,
  parameter bit BYTE_EN     = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  lc3b_word         instr,
  output logic             out_valid,
  input  logic             out_ready,
  output lc3b_control_word ctrl,
  output logic             uop_idx,
  output logic             uop_last,
  output logic             illegal,
  output logic             busy
);

  localparam logic [0:0] S_ISSUE = 1'b0;
  localparam logic [0:0] S_SEQ   = 1'b1;

  logic [0:0]       state;
  lc3b_word         instr_q;
  logic             out_free;
  logic             accept;
  lc3b_word         dec_instr;
  lc3b_uop_phase    dec_phase;
  lc3b_control_word dec_ctrl;
  logic             dec_multi;
  logic             dec_illegal;

  assign busy      = (state == S_SEQ);
  assign out_free  = !out_valid || out_ready;
  assign in_ready  = (state == S_ISSUE) && out_free && !flush;
  assign accept    = in_valid && in_ready;

  // One decoder serves both phases: new instruction when issuing, held one in S_SEQ
  assign dec_instr = busy ? instr_q : instr;
  assign dec_phase = busy ? PHASE_1 : PHASE_0;

  control_sequencer_uop_decode #(
    .INDIRECT_EN (INDIRECT_EN),
    .TRAP_SEQ_EN (TRAP_SEQ_EN),
    .BYTE_EN     (BYTE_EN)
  ) u_uop_decode (
    .instr   (dec_instr),
    .phase   (dec_phase),
    .ctrl    (dec_ctrl),
    .multi   (dec_multi),
    .illegal (dec_illegal)
  );

  // Sequencer state and output register; flush behaves like reset for this stage
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state     <= S_ISSUE;
      instr_q   <= '0;
      out_valid <= 1'b0;
      ctrl      <= '0;
      uop_idx   <= 1'b0;
      uop_last  <= 1'b0;
      illegal   <= 1'b0;
    end else if (state == S_SEQ) begin
      if (out_free) begin
        out_valid <= 1'b1;
        ctrl      <= dec_ctrl;
        uop_idx   <= 1'b1;
        uop_last  <= 1'b1;
        illegal   <= dec_illegal;
        state     <= S_ISSUE;
      end
    end else if (accept) begin
      out_valid <= 1'b1;
      ctrl      <= dec_ctrl;
      uop_idx   <= 1'b0;
      uop_last  <= !dec_multi;
      illegal   <= dec_illegal;
      if (dec_multi) begin
        instr_q <= instr;
        state   <= S_SEQ;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: reset, single-op issue, LDI/TRAP
// expansion with backpressure, flush, disabled-feature illegal and mid-sequence reset.
module tb_control_sequencer;
  import control_sequencer_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, flush, in_valid, out_ready;
  lc3b_word         instr;
  logic             in_ready, out_valid, uop_idx, uop_last, illegal, busy;
  lc3b_control_word ctrl;

  logic             in_valid2, out_ready2, in_ready2, out_valid2;
  logic             uop_idx2, uop_last2, illegal2, busy2;
  lc3b_word         instr2;
  lc3b_control_word ctrl2;

  int n_cmp = 0;
  int n_err = 0;
  lc3b_control_word e;

  control_sequencer dut (
    .clk (clk), .rst (rst), .flush (flush), .in_valid (in_valid),
    .in_ready (in_ready), .instr (instr), .out_valid (out_valid),
    .out_ready (out_ready), .ctrl (ctrl), .uop_idx (uop_idx),
    .uop_last (uop_last), .illegal (illegal), .busy (busy)
  );

  control_sequencer #(.INDIRECT_EN(1'b0)) dut_noind (
    .clk (clk), .rst (rst), .flush (1'b0), .in_valid (in_valid2),
    .in_ready (in_ready2), .instr (instr2), .out_valid (out_valid2),
    .out_ready (out_ready2), .ctrl (ctrl2), .uop_idx (uop_idx2),
    .uop_last (uop_last2), .illegal (illegal2), .busy (busy2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic lc3b_control_word base(input lc3b_opcode op);
    lc3b_control_word w;
    w                 = '0;
    w.opcode          = op;
    w.mem_byte_enable = 2'b11;
    return w;
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; instr = '0;
    in_valid2 = 1'b0; out_ready2 = 1'b1; instr2 = '0;
    step(); step();
    rst = 1'b0;

    // reset state
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_illegal",   32'(illegal),   32'd0);
    chk("rst_uop_idx",   32'(uop_idx),   32'd0);
    chk("rst_uop_last",  32'(uop_last),  32'd0);
    chk("rst_ctrl",      32'(ctrl),      32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);

    // ADD R1,R2,#5
    in_valid = 1'b1; instr = 16'h12A5;
    step();
    in_valid = 1'b0;
    e = base(OP_ADD); e.aluop = ALU_ADD; e.alumux_sel = ALUMUX_IMM5;
    e.load_regfile = 1'b1; e.load_cc = 1'b1;
    chk("add_valid",    32'(out_valid), 32'd1);
    chk("add_ctrl",     32'(ctrl),      32'(e));
    chk("add_last",     32'(uop_last),  32'd1);
    chk("add_idx",      32'(uop_idx),   32'd0);
    chk("add_in_ready", 32'(in_ready),  32'd1);
    step();
    chk("add_drain", 32'(out_valid), 32'd0);

    // SHF R1,R0,#1 arithmetic right
    in_valid = 1'b1; instr = 16'hD231;
    step();
    in_valid = 1'b0;
    chk("shf_aluop", 32'(ctrl.aluop), 32'(ALU_SRA));
    step();

    // RTI is always illegal
    in_valid = 1'b1; instr = 16'h8000;
    step();
    in_valid = 1'b0;
    chk("rti_illegal", 32'(illegal),  32'd1);
    chk("rti_ctrl",    32'(ctrl),     32'h8 << ($bits(lc3b_control_word) - 4));
    chk("rti_last",    32'(uop_last), 32'd1);
    step();

    // LDI R0,R1,#2 followed by ADD
    in_valid = 1'b1; instr = 16'hA042;
    step();
    instr = 16'h12A5;
    e = base(OP_LDI); e.is_ldi = 1'b1; e.mem_read = 1'b1;
    e.alumux_sel = ALUMUX_OFF6; e.aluop = ALU_ADD;
    chk("ldi0_ctrl",     32'(ctrl),     32'(e));
    chk("ldi0_addr",     32'(ctrl.addr_sel), 32'(ADDR_ALU));
    chk("ldi0_last",     32'(uop_last), 32'd0);
    chk("ldi0_busy",     32'(busy),     32'd1);
    chk("ldi0_in_ready", 32'(in_ready), 32'd0);
    step();
    e = base(OP_LDI); e.is_ldi = 1'b1; e.mem_read = 1'b1; e.addr_sel = ADDR_MDR;
    e.load_regfile = 1'b1; e.regfilemux_sel = RFMUX_MDR; e.load_cc = 1'b1;
    chk("ldi1_ctrl",     32'(ctrl),     32'(e));
    chk("ldi1_idx",      32'(uop_idx),  32'd1);
    chk("ldi1_last",     32'(uop_last), 32'd1);
    chk("ldi1_in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("ldi_add_op",   32'(ctrl.opcode), 32'(OP_ADD));
    chk("ldi_add_idx",  32'(uop_idx),     32'd0);
    chk("ldi_add_last", 32'(uop_last),    32'd1);
    step();

    // TRAP x25 with 3 cycles of backpressure on phase 0
    in_valid = 1'b1; instr = 16'hF025; out_ready = 1'b0;
    step();
    in_valid = 1'b0; instr = 16'h0000;
    e = base(OP_TRAP); e.is_trap = 1'b1; e.mem_read = 1'b1; e.addr_sel = ADDR_TRAPVEC;
    e.load_regfile = 1'b1; e.regfilemux_sel = RFMUX_PC;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("trap0_hold%0d", i), 32'(ctrl), 32'(e));
      chk($sformatf("trap0_valid%0d", i), 32'(out_valid & busy & !uop_idx), 32'd1);
      if (i < 2) step();
    end
    out_ready = 1'b1;
    step();
    e = base(OP_TRAP); e.is_trap = 1'b1; e.is_j = 1'b1; e.aluop = ALU_PASS;
    chk("trap1_ctrl", 32'(ctrl),    32'(e));
    chk("trap1_idx",  32'(uop_idx), 32'd1);
    chk("trap1_busy", 32'(busy),    32'd0);
    step();
    chk("trap_drain", 32'(out_valid), 32'd0);

    // STI flushed during phase 0
    in_valid = 1'b1; instr = 16'hB042;
    step();
    in_valid = 1'b0;
    chk("sti0_busy", 32'(busy), 32'd1);
    flush = 1'b1; out_ready = 1'b0; in_valid = 1'b1; instr = 16'h12A5;
    #1;
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_busy",  32'(busy),      32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("flush_quiet%0d", i), 32'(out_valid), 32'd0);
    end

    // LDI with indirect disabled
    in_valid2 = 1'b1; instr2 = 16'hA042;
    step();
    in_valid2 = 1'b0;
    chk("noind_valid",   32'(out_valid2),     32'd1);
    chk("noind_illegal", 32'(illegal2),       32'd1);
    chk("noind_memrd",   32'(ctrl2.mem_read), 32'd0);
    chk("noind_last",    32'(uop_last2),      32'd1);
    chk("noind_busy",    32'(busy2),          32'd0);
    step();

    // reset in the middle of a sequence
    in_valid = 1'b1; instr = 16'hA042; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    chk("rstseq_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstseq_valid", 32'(out_valid), 32'd0);
    chk("rstseq_busy2", 32'(busy),      32'd0);
    chk("rstseq_ctrl",  32'(ctrl),      32'd0);
    chk("rstseq_flags", 32'({illegal, uop_idx, uop_last}), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Registered decode/micro-sequencing stage for the pipelined LC-3b core, between the IF/ID register and the ID/EX register. Accepts one 16-bit instruction per valid/ready handshake and emits one or two control-word micro-ops per instruction. LDI, STI and TRAP are split into two memory-phase micro-ops, so downstream stages never need multi-access state. Supports per-feature enables, pipeline flush and backpressure.

## Interface
- INDIRECT_EN, 1: 1 = LDI/STI expand to two micro-ops; 0 = LDI/STI are illegal.
- TRAP_SEQ_EN, 1: 1 = TRAP expands to two micro-ops; 0 = TRAP is a single micro-op (vector read plus R7 link, no jump phase).
- BYTE_EN, 1: 1 = LDB/STB decode; 0 = LDB/STB are illegal.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard the held output and any pending second micro-op.
- in_valid  in  1  instr is valid.
- in_ready  out  1  instruction accepted when in_valid && in_ready.
- instr  in  16  lc3b_word instruction from IF/ID.
- out_valid  out  1  ctrl/uop_idx/uop_last/illegal are valid.
- out_ready  in  1  ID/EX can take the micro-op.
- ctrl  out  lc3b_control_word  control word for the micro-op.
- uop_idx  out  1  0 = first micro-op, 1 = second.
- uop_last  out  1  final micro-op of the instruction.
- illegal  out  1  opcode not supported under the current parameters.
- busy  out  1  state is S_SEQ.

## Operation
- States:
  - S_ISSUE: accepting new instructions.
  - S_SEQ: second micro-op pending; the instruction is held in instr_q.
- in_ready = (state == S_ISSUE) && (!out_valid || out_ready) && !flush.
- Accept in S_ISSUE:
  - The output register loads uop_decode(instr, phase 0). out_valid goes to 1.
  - If the opcode is multi-op, instr_q <= instr and the state becomes S_SEQ.
- In S_SEQ, when the output is free (!out_valid || out_ready):
  - The output loads phase 1. uop_idx = 1, uop_last = 1.
  - The state returns to S_ISSUE.
- Micro-op contents (fields not listed are 0, mem_byte_enable = 11, opcode = instr[15:12]):
  - LDI phase 0: is_ldi, mem_read, alumux_sel = 01, aluop = add.
  - LDI phase 1: is_ldi, mem_read, addr_sel = 10 (MDR as address), load_regfile, regfilemux_sel = 001, load_cc.
  - STI phase 0: is_sti, mem_read, alumux_sel = 01, aluop = add.
  - STI phase 1: is_sti, mem_write, addr_sel = 10.
  - TRAP phase 0: is_trap, mem_read, addr_sel = 01, load_regfile, regfilemux_sel = 010 (R7 <= PC).
  - TRAP phase 1: is_trap, is_j, aluop = pass (PC <= MDR).
  - All other opcodes: single micro-op using the standard per-opcode decode. This includes ADD/AND imm_mode on instr[5], JSR/JSRR on instr[11], and SHF on instr[5:4].
- Illegal opcode (RTI, or a feature disabled by parameter):
  - Emits a single micro-op with ctrl = 0 except the opcode field, illegal = 1, uop_last = 1.
- flush (highest priority):
  - Next cycle: out_valid = 0, state = S_ISSUE, instr_q is don't-care.
  - No instruction is accepted in the flush cycle.
- Simultaneous out_ready and accept: the old micro-op retires and the new one loads in the same edge (no bubble).

## Timing
- Reset values:
  - out_valid = 0, state = S_ISSUE, busy = 0, illegal = 0, uop_idx = 0, uop_last = 0.
  - ctrl = 0, and in_ready = 1 once rst deasserts.
- Latency: accept at edge N gives out_valid at N+1. Phase 1 is presented at the edge after phase 0 handshakes, at the earliest N+2.
- Throughput: 1 instruction/cycle for single-op instructions; 2 cycles for multi-op instructions.
- Holding: outputs stay stable while out_valid && !out_ready.
- rst mid-sequence: the pending phase 1 is dropped, with the same result as flush.

## Structure
- Add to lc3b_types:
  - addr_sel encoding constants: ADDR_ALU = 00, ADDR_TRAPVEC = 01, ADDR_MDR = 10.
  - lc3b_uop_phase typedef.
  - The illegal flag, if ctrl is extended.
- Sub-module uop_decode: combinational; (opcode, instr bits, phase, parameters) -> ctrl, multi, illegal. The sequencer holds only state, instr_q and the output register.

## Test plan
- ADD R1,R2,#5 (0x12A5) with out_ready = 1 -> next cycle:
  - out_valid = 1, aluop = add, load_regfile = 1, load_cc = 1, uop_last = 1.
  - in_ready stays 1.
- LDI R0,R1,#2 (0xA042), then ADD on the following cycle -> three outputs in order:
  - LDI phase 0: mem_read, addr_sel = 00.
  - LDI phase 1: addr_sel = 10, load_regfile, uop_last.
  - Then the ADD.
  - in_ready is 0 for exactly one cycle.
- TRAP x25 (0xF025) with out_ready low for 3 cycles -> phase 0 is held stable for 3 cycles, then phase 1 (is_j = 1) follows the handshake.
- STI accepted, flush asserted during phase 0 -> next cycle out_valid = 0 and busy = 0. No mem_write micro-op ever appears.
- INDIRECT_EN = 0, LDI -> one micro-op with illegal = 1, mem_read = 0, uop_last = 1.
- rst asserted while busy = 1 -> all outputs return to their reset values on the next edge.
